// File: rtl/vga_timing_monitor.sv
// Receive-side VGA timing checker: measures line/frame/sync geometry of an incoming
// sync+blank stream, recovers pixel coordinates and declares lock after clean frames.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 1344,
    parameter int V_TOTAL     = 806,
    parameter int H_SYNC_LEN  = 112,
    parameter int V_SYNC_LEN  = 6,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    // sync/blank fields of the upstream vga_if stream (hcount, vcount, rgb are not needed)
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblnk,
    input  logic        vblnk,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic        locked,
    output logic [11:0] line_len,
    output logic [10:0] frame_lines,
    output logic        err,
    output logic [7:0]  err_count
);
    localparam logic [11:0] H_TOTAL_W = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_W  = 12'(H_SYNC_LEN);
    localparam logic [11:0] TIMEOUT_W = 12'(2 * H_TOTAL);
    localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);
    localparam logic [10:0] V_SYNC_W  = 11'(V_SYNC_LEN);
    localparam logic [7:0]  LOCK_W    = 8'(LOCK_FRAMES);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic        hsync_q, vsync_q, hblnk_q, vblnk_q;
    logic [11:0] pcnt, hw_cnt;
    logic [10:0] lcnt, vw_cnt;
    logic        frame_bad;
    logic [1:0]  state, state_nxt;
    logic [7:0]  good_cnt, good_nxt;

    logic        hs_rise, hs_fall, vs_rise, vs_fall, hb_fall, vb_fall;
    logic [11:0] period_new;
    logic [10:0] lines_new;
    logic        line_err, vw_fail, frame_good, timeout;

    assign hs_rise = hsync & ~hsync_q;
    assign hs_fall = ~hsync & hsync_q;
    assign vs_rise = vsync & ~vsync_q;
    assign vs_fall = ~vsync & vsync_q;
    assign hb_fall = hblnk_q & ~hblnk;
    assign vb_fall = vblnk_q & ~vblnk;

    assign period_new = pcnt + 12'd1;
    assign lines_new  = lcnt + {10'd0, hs_rise};

    // The verdict folds in errors seen on the vsync-rise cycle itself, before frame_bad clears.
    assign line_err   = (hs_rise & (period_new != H_TOTAL_W)) | (hs_fall & (hw_cnt != H_SYNC_W));
    assign vw_fail    = vs_fall & (vw_cnt != V_SYNC_W);
    assign frame_good = ~(frame_bad | line_err | vw_fail) & (lines_new == V_TOTAL_W);
    assign timeout    = (pcnt == TIMEOUT_W);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_nxt = state;
        good_nxt  = good_cnt;
        if (timeout) begin
            state_nxt = SEARCH;
        end else begin
            case (state)
                SEARCH: if (vs_rise) begin
                    state_nxt = VERIFY;
                    good_nxt  = 8'd0;
                end
                VERIFY: if (vs_rise) begin
                    if (frame_good) begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_W) state_nxt = LOCKED;
                    end else begin
                        good_nxt = 8'd0;
                    end
                end
                LOCKED: if (line_err || (vs_rise && !frame_good)) state_nxt = SEARCH;
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            pcnt        <= 12'd0;
            hw_cnt      <= 12'd0;
            lcnt        <= 11'd0;
            vw_cnt      <= 11'd0;
            frame_bad   <= 1'b0;
            line_len    <= 12'd0;
            frame_lines <= 11'd0;
            x           <= 11'd0;
            y           <= 11'd0;
            de          <= 1'b0;
            state       <= SEARCH;
            good_cnt    <= 8'd0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            // NOTE: non-blocking throughout, so every term above sees pre-edge values.
            hsync_q <= hsync;
            vsync_q <= vsync;
            hblnk_q <= hblnk;
            vblnk_q <= vblnk;

            if (hs_rise) begin
                line_len <= period_new;
                pcnt     <= 12'd0;
            end else if (pcnt != 12'hFFF) begin
                pcnt <= pcnt + 12'd1;
            end

            if (vs_rise) begin
                frame_lines <= lines_new;
                lcnt        <= 11'd0;
            end else if (hs_rise && lcnt != 11'h7FF) begin
                lcnt <= lcnt + 11'd1;
            end

            if (hs_rise)                        hw_cnt <= 12'd1;
            else if (hsync && hw_cnt != 12'hFFF) hw_cnt <= hw_cnt + 12'd1;

            if (vs_rise)                                    vw_cnt <= {10'd0, hs_rise};
            else if (vsync && hs_rise && vw_cnt != 11'h7FF) vw_cnt <= vw_cnt + 11'd1;

            if (vs_rise)                  frame_bad <= 1'b0;
            else if (line_err || vw_fail) frame_bad <= 1'b1;

            x  <= hb_fall ? 11'd0 : x + 11'd1;
            if (vb_fall)      y <= 11'd0;
            else if (hb_fall) y <= y + 11'd1;
            de <= ~hblnk & ~vblnk;

            state    <= state_nxt;
            good_cnt <= good_nxt;

            // Lock only ever leaves LOCKED toward SEARCH, so a falling locked is a loss.
            locked <= (state == LOCKED);
            err    <= locked & (state != LOCKED);
            if (locked && state != LOCKED && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a shrunken 8x5 raster so full
// lock/loss sequences (including err_count saturation) fit in a short run.
module tb_vga_timing_monitor;
    localparam int HT = 8, VT = 5, HSL = 2, VSL = 1, LF = 2;
    localparam int H_ACT = 4, HS_START = 5, V_ACT = 2, VS_START = 3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        hsync = 1'b0, vsync = 1'b0, hblnk = 1'b0, vblnk = 1'b0;
    logic [10:0] x, y, frame_lines;
    logic        de, locked, err;
    logic [11:0] line_len;
    logic [7:0]  err_count;

    int checks = 0, errors = 0;
    int hc = 0, vc = 0, drv_hc = 0, drv_vc = 0, exp_hc = 0, exp_vc = 0;
    logic exp_de = 1'b0;
    int hs_len = HSL, vsr_cnt = 0, err_seen, locked_seen, exp_cnt, target;
    bit freeze = 0, short_line = 0, hs_rise_drv = 0;

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC_LEN(HSL), .V_SYNC_LEN(VSL), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
        .x(x), .y(y), .de(de), .locked(locked), .line_len(line_len),
        .frame_lines(frame_lines), .err(err), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One pixel clock of the reference raster; returns at the following negedge.
    task automatic pixel();
        bit hs_n, vs_n;
        @(posedge clk);
        #1;
        exp_hc = drv_hc;
        exp_vc = drv_vc;
        exp_de = !hblnk && !vblnk;
        if (!freeze) begin
            hs_n = (hc >= HS_START) && (hc < HS_START + hs_len);
            vs_n = (vc >= VS_START) && (vc < VS_START + VSL);
            hs_rise_drv = hs_n && !hsync;
            if (vs_n && !vsync) vsr_cnt++;
            hsync  = hs_n;
            vsync  = vs_n;
            hblnk  = (hc >= H_ACT);
            vblnk  = (vc >= V_ACT);
            drv_hc = hc;
            drv_vc = vc;
            if (hc == HT - 1 || (short_line && hc == HT - 2)) begin
                if (hc == HT - 2) short_line = 0;
                hc = 0;
                vc = (vc == VT - 1) ? 0 : vc + 1;
            end else begin
                hc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_vsr(input int n);
        target = vsr_cnt + n;
        for (int i = 0; i < 2000 && vsr_cnt < target; i++) pixel();
        if (vsr_cnt < target) check("vsync_wait_timeout", vsr_cnt, target);
    endtask

    task automatic wait_lock();
        for (int i = 0; i < 400 && !locked; i++) pixel();
        check("lock_wait", locked, 1);
    endtask

    task automatic wait_unlock();
        for (int i = 0; i < 40 && locked; i++) pixel();
        check("unlock_wait", locked, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_x"}, x, 0);
        check({tag, "_y"}, y, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_line_len"}, line_len, 0);
        check({tag, "_frame_lines"}, frame_lines, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Lock acquisition from reset
        run_until_vsr(2);
        pixel();
        check("line_len_first", line_len, HT);
        check("frame_lines_first", frame_lines, VT);
        check("locked_before_third", locked, 0);
        run_until_vsr(1);
        pixel();
        check("lock_plus1", locked, 0);
        pixel();
        check("lock_plus2", locked, 1);

        // Coordinates and de track the previous input sample
        for (int i = 0; i < 2 * HT * VT; i++) begin
            pixel();
            check("de_x_y", {9'd0, de, x, y}, {9'd0, exp_de, 11'(exp_hc), 11'(exp_vc)});
        end
        check("err_count_clean", err_count, 0);
        check("locked_clean", locked, 1);

        // One line shortened by a clock while locked
        run_until_vsr(1);
        short_line = 1;
        err_seen = 0;
        for (int i = 0; i < 20; i++) begin
            pixel();
            if (err) err_seen++;
        end
        check("short_err_cycles", err_seen, 1);
        check("short_err_count", err_count, 1);
        check("short_locked", locked, 0);
        run_until_vsr(3);
        pixel();
        check("relock_plus1", locked, 0);
        pixel();
        check("relock_plus2", locked, 1);

        // Frozen inputs: timeout at 2*H_TOTAL after the last hsync rise
        for (int i = 0; i < 2 * HT && !hs_rise_drv; i++) pixel();
        freeze = 1;
        repeat (2 * HT + 2) pixel();
        check("freeze_hold", locked, 1);
        pixel();
        check("freeze_lost", locked, 0);
        check("freeze_err", err, 1);
        check("freeze_err_count", err_count, 2);
        pixel();
        check("freeze_err_end", err, 0);
        freeze = 0;

        // Hsync one clock too narrow on every line
        rst = 1'b1;
        pixel();
        rst = 1'b0;
        hs_len = HSL - 1;
        locked_seen = 0;
        target = vsr_cnt + 5;
        for (int i = 0; i < 2000 && vsr_cnt < target; i++) begin
            pixel();
            if (locked) locked_seen++;
        end
        repeat (3) begin
            pixel();
            if (locked) locked_seen++;
        end
        check("narrow_locked_cycles", locked_seen, 0);
        check("narrow_line_len", line_len, HT);
        check("narrow_err_count", err_count, 0);
        hs_len = HSL;

        // Asynchronous reset mid-frame while locked
        wait_lock();
        for (int i = 0; i < 100 && !(drv_vc == 1 && drv_hc == 2); i++) pixel();
        check("pre_reset_y", y, 1);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (3) pixel();
        check("reset_hold_x", x, 0);
        check("reset_hold_line_len", line_len, 0);
        rst = 1'b0;
        run_until_vsr(3);
        pixel();
        check("post_reset_plus1", locked, 0);
        pixel();
        check("post_reset_plus2", locked, 1);

        // err_count saturation over 260 losses
        rst = 1'b1;
        pixel();
        rst = 1'b0;
        wait_lock();
        exp_cnt = 0;
        for (int i = 0; i < 260; i++) begin
            short_line = 1;
            wait_unlock();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            if (i == 253 || i == 254 || i == 259) check("sat_err_count", err_count, exp_cnt);
            wait_lock();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
